// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Optional packet lock is enabled by defining FIFO_ARB_PKT_LOCK_EN.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   function automatic int unsigned src_id_w(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle for fifo_wr_arbiter; slave is the arbiter, master the environment.
// i_last is only consumed when FIFO_ARB_PKT_LOCK_EN is defined.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned INT_NUM_SRC    = 4,
   parameter int unsigned INT_FIFO_WIDTH = 32
);
   localparam int unsigned IdW = src_id_w(INT_NUM_SRC);

   logic [INT_NUM_SRC*INT_FIFO_WIDTH-1:0] i_data;
   logic [INT_NUM_SRC-1:0]                i_valid;
   logic [INT_NUM_SRC-1:0]                i_last;
   logic [INT_NUM_SRC-1:0]                o_ready;
   logic [INT_FIFO_WIDTH-1:0]             o_data;
   logic                                  o_valid;
   logic                                  i_ready;
   logic [IdW-1:0]                        o_src_id;

   modport master (
      output i_data, i_valid, i_last, i_ready,
      input  o_ready, o_data, o_valid, o_src_id
   );

   modport slave (
      input  i_data, i_valid, i_last, i_ready,
      output o_ready, o_data, o_valid, o_src_id
   );

endinterface

// File: rtl/rr_grant_sel.sv
// Combinational round-robin selector: rotate requests past last_grant, pick the lowest,
// rotate the index back.
module rr_grant_sel
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]             req,
   input  logic [src_id_w(N)-1:0]   last_grant,
   output logic [src_id_w(N)-1:0]   grant,
   output logic                     grant_valid
);
   localparam int unsigned IdW = src_id_w(N);

   logic [N-1:0]   req_rot;
   int unsigned    first_rot;

   always_comb begin
      req_rot   = '0;
      first_rot = 0;
      for (int unsigned i = 0; i < N; i++) begin
         req_rot[i] = req[(int'(last_grant) + 1 + i) % N];
      end
      // Descending scan so the lowest rotated position wins.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_rot[i]) first_rot = int'(i);
      end
      grant_valid = |req_rot;
      grant       = IdW'((int'(last_grant) + 1 + first_rot) % N);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_cdcc write port among several producers, with a single
// registered output slot. Define FIFO_ARB_PKT_LOCK_EN to hold the grant for whole packets.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned INT_NUM_SRC    = 4,
   parameter int unsigned INT_FIFO_WIDTH = 32
) (
   input logic              wr_clk,
   input logic              wr_rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int unsigned N   = INT_NUM_SRC;
   localparam int unsigned W   = INT_FIFO_WIDTH;
   localparam int unsigned IdW = src_id_w(N);

   logic [W-1:0]   src_data [N];
   logic [N-1:0]   req;
   logic [IdW-1:0] grant;
   logic           grant_valid;
   logic           can_load;
   logic           accept;

   logic [IdW-1:0] last_grant_q, last_grant_d;
   logic [W-1:0]   data_q, data_d;
   logic [IdW-1:0] src_q, src_d;
   logic           valid_q, valid_d;

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign src_data[g] = bus.i_data[g*W +: W];
   end

`ifdef FIFO_ARB_PKT_LOCK_EN
   arb_state_e     state_q, state_d;
   logic [IdW-1:0] lock_id_q, lock_id_d;
   logic [N-1:0]   lock_mask;

   assign lock_mask = {{(N-1){1'b0}}, 1'b1} << lock_id_q;
   assign req       = (state_q == ST_LOCKED) ? (bus.i_valid & lock_mask) : bus.i_valid;

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept && !bus.i_last[grant]) begin
               state_d   = ST_LOCKED;
               lock_id_d = grant;
            end
         end
         ST_LOCKED: begin
            if (accept && bus.i_last[grant]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wr_clk) begin
      if (!wr_rst) begin
         state_q   <= ST_IDLE;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end
`else
   logic [N-1:0] unused_last;
   assign unused_last = bus.i_last;
   assign req         = bus.i_valid;
`endif

   rr_grant_sel #(
      .N (N)
   ) u_sel (
      .req         (req),
      .last_grant  (last_grant_q),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign can_load = !valid_q || bus.i_ready;
   // Gated by reset so no beat is offered while the block is being cleared.
   assign accept   = wr_rst && can_load && grant_valid;

   always_comb begin
      bus.o_ready = '0;
      for (int unsigned k = 0; k < N; k++) begin
         bus.o_ready[k] = accept && (grant == IdW'(k));
      end
   end

   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      src_d        = src_q;
      last_grant_d = last_grant_q;
      if (accept) begin
         valid_d      = 1'b1;
         data_d       = src_data[grant];
         src_d        = grant;
         last_grant_d = grant;
      end else if (valid_q && bus.i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge wr_clk) begin
      if (!wr_rst) begin
         valid_q      <= 1'b0;
         data_q       <= '0;
         src_q        <= '0;
         last_grant_q <= IdW'(N - 1);
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         src_q        <= src_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.o_valid  = valid_q;
   assign bus.o_data   = data_q;
   assign bus.o_src_id = src_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Single-clock N-way round-robin arbiter that shares the write port of one `fifo_cdcc` instance between several valid/ready producers in the write clock domain. It selects one requester per beat, registers the selected data and source ID in a single output stage, and drives the FIFO's `i_data`/`i_valid` while obeying the FIFO's `o_ready`. An optional packet-lock mode holds the grant until a packet's last beat.

## Interface
- `INT_NUM_SRC`, 4: number of requesters, 2..16.
- `INT_FIFO_WIDTH`, 32: data width per requester, equal to the FIFO's `INT_FIFO_WIDTH`.
- `wr_clk`  in  1  clock, the same clock as the FIFO's `wr_clk`.
- `wr_rst`  in  1  reset, synchronous and active-low: the block resets on a `wr_clk` edge while `wr_rst` = 0.
- `i_data`  in  `INT_NUM_SRC*INT_FIFO_WIDTH`  requester data, flattened; source k occupies bits [k*W +: W].
- `i_valid`  in  `INT_NUM_SRC`  per-requester valid.
- `i_last`  in  `INT_NUM_SRC`  per-requester last-beat flag. Used only with `FIFO_ARB_PKT_LOCK_EN`; ignored otherwise.
- `o_ready`  out  `INT_NUM_SRC`  per-requester ready, one-hot or zero.
- `o_data`  out  `INT_FIFO_WIDTH`  registered data to the FIFO's `i_data`.
- `o_valid`  out  1  registered valid to the FIFO's `i_valid`.
- `i_ready`  in  1  from the FIFO's `o_ready`.
- `o_src_id`  out  `max(1,$clog2(INT_NUM_SRC))`  source index of the beat currently on `o_data`.

## Operation
- **Output slot.** One register stage holds `o_data`, `o_src_id` and `o_valid`.
  - The slot can load when `can_load = !o_valid || i_ready`.
- **Grant.**
  - `grant` is the first k with `i_valid[k]` = 1, scanning from `(last_grant+1) mod INT_NUM_SRC` upward with wrap-around.
  - `grant` is combinational from `i_valid`, `last_grant` and the lock state.
- **Ready.** `o_ready[k] = can_load && grant_valid && grant == k`.
  - Ready never asserts for a source whose `i_valid` is low.
- **Accept.** A beat is accepted when `i_valid[k] && o_ready[k]`. On accept:
  - the slot loads `i_data[k]` and `o_src_id` = k;
  - `o_valid` = 1;
  - `last_grant` = k.
- **Drain.** If the slot drains (`o_valid && i_ready`) with no new accept in that cycle, `o_valid` = 0.
  - Simultaneous drain and accept keeps `o_valid` = 1 and replaces the contents, giving full throughput of 1 beat/cycle.
- **Holding.** While `o_valid && !i_ready`, `o_data` and `o_src_id` stay stable.
- **Arbitration states** (used when lock is enabled): IDLE and LOCKED.
  - IDLE → LOCKED: a beat is accepted with `i_last` = 0; `lock_id` is set to that source.
  - LOCKED: `grant` is forced to `lock_id` regardless of other requesters. Other sources see `o_ready` = 0.
  - LOCKED → IDLE: a beat from `lock_id` is accepted with `i_last` = 1.
  - A beat accepted in IDLE with `i_last` = 1 stays in IDLE (single-beat packet).
- **No requesters.** If all `i_valid` = 0, `grant_valid` = 0 and `last_grant` is unchanged.

## Timing
- **Reset values:**
  - `o_valid` = 0, `o_data` = 0, `o_src_id` = 0;
  - `o_ready` = 0 during the reset cycle;
  - `last_grant` = `INT_NUM_SRC-1`, so source 0 has top priority first;
  - state = IDLE.
- **Reset mid-packet:** the next edge with `wr_rst` = 0 returns to IDLE and discards the slot contents.
- **Latency:** an accepted beat appears on `o_valid`/`o_data` on the next `wr_clk` edge.
  - `o_ready` depends combinationally on `i_ready`, the FIFO's registered full flag.
- **Fairness:** with all sources continuously valid and `i_ready` = 1, grants rotate 0,1,…,N-1,0 with one beat per source.
  - A waiting source is served within N-1 accepted beats (non-lock mode).

## Configuration
- `FIFO_ARB_PKT_LOCK_EN` defined:
  - the IDLE/LOCKED state machine and `i_last` are used;
  - the grant is held for a whole packet.
- Not defined:
  - `i_last` is left unconnected internally;
  - the state machine is not generated;
  - every accepted beat re-arbitrates.

## Structure
- **Shared package `fifo_arb_pkg`:**
  - function computing the `o_src_id` width;
  - state encoding constants `ST_IDLE`/`ST_LOCKED`.
- **Sub-module `rr_grant_sel`:** combinational rotate / priority-encode / unrotate, with inputs `req[N]`, `last_grant` and output `grant`, `grant_valid`. The top holds the registers and the state machine.

## Test plan
- **Reset:** hold `wr_rst` = 0 for 3 cycles with all `i_valid` = 1 → `o_valid` = 0, `o_ready` = 0, `o_data` = 0. First accept after release is source 0.
- **Fair rotation:** N=4, all valid, `i_ready` = 1, source k sends 0xA0+k → `o_src_id` sequence 0,1,2,3,0,… with matching data, one beat per cycle.
- **Backpressure:** `i_ready` = 0 for 5 cycles while `o_valid` = 1 → `o_data` is held and all `o_ready` = 0. On release, the next beat follows with no gap.
- **Sparse requests:** only sources 1 and 3 valid → alternating 1,3,1,3. Source 0 later raised after a grant to 3 → 0 is granted next.
- **Packet lock** (macro on): source 2 sends a 4-beat packet (`i_last` on beat 4) while 0 and 1 are valid → `o_src_id` = 2,2,2,2, then 0.
- **Reset mid-packet:** reset asserted during beat 2 of a locked packet → IDLE after reset; the next grant is source 0.
